vx_icache_req_arb: RTL

VX_ICACHE_REQ_ARB -- requirements
Module: VX_icache_req_arb

---
 rtl/vx_icache_req_arb.sv | 93 +++++++++
 1 files changed

// File: rtl/vx_icache_req_arb.sv
// Round-robin arbiter: NUM_REQS requesters share one registered icache port.
// Ports: clk, reset_n, req_valid/addr/tag/ready (per requester), icache_valid/
// addr/tag/ready (shared, tag = {req_tag, index}). Optional per-requester grant
// counters on perf_grants when VX_ICACHE_ARB_PERF_EN is defined.
module vx_icache_req_arb #(
  parameter int NUM_REQS      = 4,
  parameter int ADDR_WIDTH    = 30,
  parameter int TAG_IN_WIDTH  = 8,
  localparam int LOG_REQS     = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_REQS
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic                             icache_valid,
  output logic [ADDR_WIDTH-1:0]            icache_addr,
  output logic [TAG_OUT_WIDTH-1:0]         icache_tag,
  input  logic                             icache_ready
`ifdef VX_ICACHE_ARB_PERF_EN
  ,
  output logic [NUM_REQS*32-1:0]           perf_grants
`endif
);

  logic [LOG_REQS-1:0] ptr;
  logic [LOG_REQS-1:0] win;
  logic                any_valid;
  logic                slot_free;
  logic                grant;

  // Scan from the highest offset down so the nearest valid
  // requester at or after the pointer is the last one written.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    for (int k = NUM_REQS-1; k >= 0; k--) begin
      if (req_valid[ptr + LOG_REQS'(k)]) begin
        any_valid = 1'b1;
        win       = ptr + LOG_REQS'(k);
      end
    end
  end

  assign slot_free = !icache_valid || icache_ready;
  assign grant     = reset_n && any_valid && slot_free;

  always_comb begin
    req_ready = '0;
    if (grant)
      req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      icache_valid <= 1'b0;
      ptr          <= '0;
    end else if (grant) begin
      icache_valid <= 1'b1;
      ptr          <= win + LOG_REQS'(1);
    end else if (icache_ready) begin
      icache_valid <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while icache_valid.
  always_ff @(posedge clk) begin
    if (grant) begin
      icache_addr <= req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
      icache_tag  <= {req_tag[int'(win)*TAG_IN_WIDTH +: TAG_IN_WIDTH], win};
    end
  end

`ifdef VX_ICACHE_ARB_PERF_EN
  logic [31:0] cnt [NUM_REQS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQS; i++)
        cnt[i] <= '0;
    end else if (grant) begin
      cnt[win] <= cnt[win] + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf
    assign perf_grants[g*32 +: 32] = cnt[g];
  end
`endif

endmodule
